// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry
// Purpose  : Keypad-side responder to the calculator control FSM. While the
//            control state is EXECA it collects decimal keystrokes into
//            operand A, an operator and operand B. It then raises a one-cycle
//            'inputed' pulse and holds the operands stable for EXECB.
// Ports    : CLK        system clock (posedge)
//            RST        synchronous reset, active low
//            state      control FSM state code
//            key_valid  one-cycle key strobe
//            key_code   0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear
//            op_a/op_b  binary operands, modulo 2^WIDTH
//            opcode     0 add, 1 sub, 2 mul, 3 div
//            inputed    one-cycle pulse, entry complete
//            phase      0 WAIT, 1 ENTER_A, 2 ENTER_B, 3 DONE
// Revision : 1.0  initial release
// ============================================================================
module operand_entry #(
    parameter int         WIDTH       = 16,
    parameter int         MAX_DIGITS  = 4,
    parameter logic [2:0] STATE_EXECA = 3'd1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       state,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       opcode,
    output logic             inputed,
    output logic [1:0]       phase
);

    localparam int                CW     = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]     c_MAXD = CW'(MAX_DIGITS);
    localparam logic [CW-1:0]     c_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]  c_TEN  = WIDTH'(10);

    typedef enum logic [1:0] {
        PH_WAIT    = 2'd0,
        PH_ENTER_A = 2'd1,
        PH_ENTER_B = 2'd2,
        PH_DONE    = 2'd3
    } phase_t;

    phase_t           phase_q,   phase_d;
    logic [WIDTH-1:0] op_a_q,    op_a_d;
    logic [WIDTH-1:0] op_b_q,    op_b_d;
    logic [1:0]       opcode_q,  opcode_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             inputed_q, inputed_d;

    logic             w_execa;
    logic             w_is_digit;
    logic             w_is_op;
    logic             w_is_eq;
    logic             w_is_clr;
    logic [1:0]       w_opsel;
    logic [WIDTH-1:0] w_acc_in;
    logic [WIDTH-1:0] w_acc;
    logic             w_room;

    assign w_execa    = (state == STATE_EXECA);
    assign w_is_digit = (key_code < 4'd10);
    assign w_is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
    assign w_is_eq    = (key_code == 4'd14);
    assign w_is_clr   = (key_code == 4'd15);
    // Codes 10..13 map to 0..3: low two bits minus 2, modulo 4.
    assign w_opsel    = key_code[1:0] - 2'd2;
    assign w_room     = (cnt_q < c_MAXD);

    // One shared decimal accumulator serves whichever operand is being entered.
    assign w_acc_in   = (phase_q == PH_ENTER_B) ? op_b_q : op_a_q;
    assign w_acc      = (w_acc_in * c_TEN) + {{(WIDTH-4){1'b0}}, key_code};

    always_comb begin
        phase_d   = phase_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        inputed_d = 1'b0;

        case (phase_q)
            PH_WAIT: begin
                if (w_execa) begin
                    phase_d  = PH_ENTER_A;
                    op_a_d   = '0;
                    op_b_d   = '0;
                    opcode_d = 2'd0;
                    cnt_d    = '0;
                end
            end

            PH_ENTER_A, PH_ENTER_B: begin
                if (!w_execa) begin
                    phase_d = PH_WAIT;
                end else if (key_valid) begin
                    if (w_is_digit) begin
                        if (w_room) begin
                            if (phase_q == PH_ENTER_A) op_a_d = w_acc;
                            else                       op_b_d = w_acc;
                            cnt_d = cnt_q + c_ONE;
                        end
                    end else if (w_is_op) begin
                        // In A an operator needs a digit first; in B it can
                        // only replace the operator before any B digit.
                        if (phase_q == PH_ENTER_A) begin
                            if (cnt_q != '0) begin
                                opcode_d = w_opsel;
                                cnt_d    = '0;
                                phase_d  = PH_ENTER_B;
                            end
                        end else if (cnt_q == '0) begin
                            opcode_d = w_opsel;
                        end
                    end else if (w_is_eq) begin
                        if ((phase_q == PH_ENTER_B) && (cnt_q != '0)) begin
                            phase_d   = PH_DONE;
                            inputed_d = 1'b1;
                        end
                    end else if (w_is_clr) begin
                        op_a_d   = '0;
                        op_b_d   = '0;
                        opcode_d = 2'd0;
                        cnt_d    = '0;
                        phase_d  = PH_ENTER_A;
                    end
                end
            end

            PH_DONE: begin
                if (!w_execa) phase_d = PH_WAIT;
            end

            default: phase_d = PH_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            phase_q   <= PH_WAIT;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= 2'd0;
            cnt_q     <= '0;
            inputed_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            inputed_q <= inputed_d;
        end
    end

    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign opcode  = opcode_q;
    assign inputed = inputed_q;
    assign phase   = phase_q;

endmodule
`default_nettype wire
